// File: rtl/nervous_shock_detector_mc_pkg.sv
// Shared definitions for the multi-channel nervous shock detector:
// level encodings and a constant-friendly ceil(log2) helper.
package nervous_shock_detector_mc_pkg;

  typedef enum logic [1:0] {
    LVL_NORMAL = 2'b00,
    LVL_MILD   = 2'b01,
    LVL_SEVERE = 2'b10,
    LVL_FAULT  = 2'b11
  } level_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nervous_shock_detector_mc_shock_channel.sv
// One detector channel: pattern matcher, sliding match window, stuck-high
// fault detection, registered severity level and sticky alarm.
module shock_channel
  import nervous_shock_detector_mc_pkg::*;
#(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b100,
  parameter int                     WINDOW      = 8,
  parameter int                     MILD_TH     = 1,
  parameter int                     SEVERE_TH   = 3,
  parameter int                     STUCK_LEN   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_valid,
  input  logic       sample,
  input  logic       clear_alarm,
  output logic [1:0] level,
  output logic       alarm
);

  localparam int CW = clog2(WINDOW + 1);
  localparam int FW = clog2(PATTERN_LEN);
  localparam int SW = clog2(STUCK_LEN + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(PATTERN_LEN - 1);
  localparam logic [CW-1:0] MILD_CNT   = CW'(MILD_TH);
  localparam logic [CW-1:0] SEVERE_CNT = CW'(SEVERE_TH);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_LEN);

  logic [PATTERN_LEN-2:0] hist;
  logic [FW-1:0]          fill;
  logic [WINDOW-1:0]      win;
  logic [CW-1:0]          count;
  logic [SW-1:0]          stuck;

  logic [PATTERN_LEN-1:0] cand;
  logic                   match;
  logic [CW-1:0]          count_nxt;
  logic [SW-1:0]          stuck_nxt;
  level_t                 level_nxt;
  logic                   alarm_nxt;

  // The fill gate keeps reset-zeroed history from forming a false match.
  always_comb begin
    cand      = {hist, sample};
    match     = (fill == FILL_FULL) && (cand == PATTERN);
    count_nxt = count + CW'(match) - CW'(win[WINDOW-1]);

    stuck_nxt = '0;
    if (sample) stuck_nxt = (stuck == STUCK_MAX) ? stuck : stuck + 1'b1;

    level_nxt = LVL_NORMAL;
    if (stuck_nxt == STUCK_MAX)       level_nxt = LVL_FAULT;
    else if (count_nxt >= SEVERE_CNT) level_nxt = LVL_SEVERE;
    else if (count_nxt >= MILD_CNT)   level_nxt = LVL_MILD;

    alarm_nxt = alarm;
    if (clear_alarm) alarm_nxt = 1'b0;
    if (sample_valid && level_nxt[1]) alarm_nxt = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist  <= '0;
      fill  <= '0;
      win   <= '0;
      count <= '0;
      stuck <= '0;
      level <= LVL_NORMAL;
      alarm <= 1'b0;
    end else begin
      if (sample_valid) begin
        hist  <= cand[PATTERN_LEN-2:0];
        if (fill != FILL_FULL) fill <= fill + 1'b1;
        win   <= {win[WINDOW-2:0], match};
        count <= count_nxt;
        stuck <= stuck_nxt;
        level <= level_nxt;
      end
      alarm <= alarm_nxt;
    end
  end

endmodule

// File: rtl/nervous_shock_detector_mc.sv
// Multi-channel nervous shock detector: one shock_channel per sensor plus a
// combinational worst-channel aggregator over the registered levels.
module nervous_shock_detector_mc
  import nervous_shock_detector_mc_pkg::*;
#(
  parameter int                     CHANNELS    = 4,
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b100,
  parameter int                     WINDOW      = 8,
  parameter int                     MILD_TH     = 1,
  parameter int                     SEVERE_TH   = 3,
  parameter int                     STUCK_LEN   = 6,
  parameter int                     IW          = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sampleValid,
  input  logic [CHANNELS-1:0]   inputdata,
  input  logic [CHANNELS-1:0]   clearAlarm,
  output logic [2*CHANNELS-1:0] nervousAbnormality,
  output logic [CHANNELS-1:0]   alarmLatched,
  output logic [1:0]            worstLevel,
  output logic [IW-1:0]         worstChannel
);

  logic [1:0] levels [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    shock_channel #(
      .PATTERN_LEN (PATTERN_LEN),
      .PATTERN     (PATTERN),
      .WINDOW      (WINDOW),
      .MILD_TH     (MILD_TH),
      .SEVERE_TH   (SEVERE_TH),
      .STUCK_LEN   (STUCK_LEN)
    ) u_channel (
      .clock        (clock),
      .reset_n      (reset_n),
      .sample_valid (sampleValid),
      .sample       (inputdata[i]),
      .clear_alarm  (clearAlarm[i]),
      .level        (levels[i]),
      .alarm        (alarmLatched[i])
    );
    assign nervousAbnormality[2*i+1:2*i] = levels[i];
  end

  // Strict greater-than keeps the lowest index among equally bad channels.
  always_comb begin
    worstLevel   = LVL_NORMAL;
    worstChannel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (levels[i] > worstLevel) begin
        worstLevel   = levels[i];
        worstChannel = IW'(i);
      end
    end
  end

endmodule
